// File: rtl/counter_sched.sv
// counter_sched: two-requester scheduler that drives an external up-counter.
// A granted job loads the requester's start value into the counter, enables
// counting until the counter reaches the requester's limit, then pulses done.
// Build option: define CNT_SCHED_RR_EN for round-robin arbitration between the
// two requesters; with it undefined, requester 0 has fixed priority.
module counter_sched #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_load,
  output logic             cnt_enable,
  input  logic [WIDTH-1:0] cnt_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             win_s;
  logic             granted_req_s;
  logic             cnt_enable_s;

  // The granted requester is still holding its request high
  assign granted_req_s = |(req & gnt_q);

`ifdef CNT_SCHED_RR_EN
  logic ptr_q, ptr_d;
  logic release_s;

  // A job releases its grant when it completes (leaving DONE) or is aborted
  assign release_s = (state_q == ST_DONE) ||
                     (((state_q == ST_LOAD) || (state_q == ST_RUN)) && !granted_req_s);

  // Round-robin pointer: after a release, favour the requester not just served
  always_comb begin
    if (release_s) begin
      ptr_d = ~gnt_q[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset favours requester 0
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Arbitration: ties go to the pointer, otherwise the sole requester wins
  always_comb begin
    if (req == 2'b11) begin
      win_s = ptr_q;
    end else begin
      win_s = req[1];
    end
  end
`else
  // Arbitration: requester 0 always beats requester 1
  always_comb begin
    if (req[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = req[1];
    end
  end
`endif

  // Next-state logic: grant, job parameter capture, completion and abort
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    start_d = start_q;
    limit_d = limit_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_LOAD;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          start_d = win_s ? start1 : start0;
          limit_d = win_s ? limit1 : limit0;
        end else begin
          gnt_d = 2'b00;
        end
      end
      ST_LOAD: begin
        if (!granted_req_s) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!granted_req_s) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else if (cnt_count == limit_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Request changes are ignored here; always pass through IDLE
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Registered-output values derived from the upcoming state
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    load_d = (state_d == ST_LOAD);
    if (state_d == ST_DONE) begin
      done_d = gnt_d;
    end else begin
      done_d = 2'b00;
    end
  end

  // Counter enable follows the live count so the final increment lands on limit
  always_comb begin
    if (state_q == ST_RUN) begin
      cnt_enable_s = (cnt_count != limit_q);
    end else begin
      cnt_enable_s = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      start_q <= {WIDTH{1'b0}};
      limit_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      start_q <= start_d;
      limit_q <= limit_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign cnt_load   = load_q;
  assign cnt_data   = start_q;
  assign cnt_enable = cnt_enable_s;

endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched with a behavioural up-counter.
module tb_counter_sched;

  logic       clk    = 1'b0;
  logic       rst_   = 1'b1;
  logic [1:0] req    = 2'b00;
  logic [4:0] start0 = 5'd0;
  logic [4:0] start1 = 5'd0;
  logic [4:0] limit0 = 5'd0;
  logic [4:0] limit1 = 5'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [4:0] cnt_data;
  logic       cnt_load;
  logic       cnt_enable;
  logic [4:0] cnt_model;

  int checks   = 0;
  int failures = 0;

  // observations collected by do_job
  logic [1:0] obs_g0;
  logic [4:0] obs_data0;
  int         obs_loads;
  int         obs_en;
  int         obs_done_edge;
  logic [1:0] obs_done_val;
  int         obs_pulses;
  logic       obs_multi;
  logic       obs_end_busy;

  always #5 clk = ~clk;

  // external counter driven by the scheduler
  always @(posedge clk or negedge rst_) begin
    if (!rst_) cnt_model <= 5'd0;
    else if (cnt_load) cnt_model <= cnt_data;
    else if (cnt_enable) cnt_model <= cnt_model + 5'd1;
  end

  counter_sched #(.WIDTH(5)) dut (
    .clk(clk), .rst_(rst_), .req(req),
    .start0(start0), .start1(start1), .limit0(limit0), .limit1(limit1),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_data(cnt_data), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_count(cnt_model)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  // Raise req, then observe cycle k = the cycle after edge k (edge 0 samples req).
  task automatic do_job(input logic [1:0] r, input int ncyc, input logic mutate);
    obs_g0 = 2'b00; obs_data0 = 5'd0; obs_loads = 0; obs_en = 0;
    obs_done_edge = -1; obs_done_val = 2'b00; obs_pulses = 0; obs_multi = 1'b0;
    @(negedge clk);
    req = r;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        obs_g0 = gnt;
        obs_data0 = cnt_data;
      end
      if (cnt_load) obs_loads++;
      if (cnt_enable) obs_en++;
      if (gnt == 2'b11) obs_multi = 1'b1;
      if (done != 2'b00) begin
        if (obs_pulses == 0) begin
          obs_done_edge = k;
          obs_done_val = done;
        end
        obs_pulses++;
        req = 2'b00;
      end
      if (k == 0 && mutate) begin
        start0 = 5'd10;
        limit0 = 5'd30;
      end
    end
    obs_end_busy = busy;
  endtask

  task automatic test_reset();
    #1 rst_ = 1'b0;
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cnt_load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", cnt_load); end
    checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", cnt_enable); end
    checks++; if (cnt_data !== 5'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", cnt_data); end
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    start0 = 5'd3; limit0 = 5'd7;
    do_job(2'b01, 10, 1'b0);
    checks++; if (obs_g0 !== 2'b01) begin failures++; $display("FAIL basic_gnt got=%b exp=01", obs_g0); end
    checks++; if (obs_data0 !== 5'd3) begin failures++; $display("FAIL basic_data got=%0d exp=3", obs_data0); end
    checks++; if (obs_loads != 1) begin failures++; $display("FAIL basic_loads got=%0d exp=1", obs_loads); end
    checks++; if (obs_en != 4) begin failures++; $display("FAIL basic_enables got=%0d exp=4", obs_en); end
    checks++; if (obs_done_edge != 6) begin failures++; $display("FAIL basic_done_edge got=%0d exp=6", obs_done_edge); end
    checks++; if (obs_done_val !== 2'b01) begin failures++; $display("FAIL basic_done_val got=%b exp=01", obs_done_val); end
    checks++; if (obs_pulses != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", obs_pulses); end
    checks++; if (obs_multi !== 1'b0) begin failures++; $display("FAIL basic_onehot got=%b exp=0", obs_multi); end
    checks++; if (obs_end_busy !== 1'b0) begin failures++; $display("FAIL basic_end_busy got=%b exp=0", obs_end_busy); end
  endtask

  task automatic test_wrap();
    start1 = 5'd30; limit1 = 5'd2;
    do_job(2'b10, 10, 1'b0);
    checks++; if (obs_g0 !== 2'b10) begin failures++; $display("FAIL wrap_gnt got=%b exp=10", obs_g0); end
    checks++; if (obs_data0 !== 5'd30) begin failures++; $display("FAIL wrap_data got=%0d exp=30", obs_data0); end
    checks++; if (obs_en != 4) begin failures++; $display("FAIL wrap_enables got=%0d exp=4", obs_en); end
    checks++; if (obs_done_edge != 6) begin failures++; $display("FAIL wrap_done_edge got=%0d exp=6", obs_done_edge); end
    checks++; if (obs_done_val !== 2'b10) begin failures++; $display("FAIL wrap_done_val got=%b exp=10", obs_done_val); end
    checks++; if (obs_pulses != 1) begin failures++; $display("FAIL wrap_pulses got=%0d exp=1", obs_pulses); end
  endtask

  task automatic test_equal();
    start0 = 5'd9; limit0 = 5'd9;
    do_job(2'b01, 6, 1'b0);
    checks++; if (obs_data0 !== 5'd9) begin failures++; $display("FAIL equal_data got=%0d exp=9", obs_data0); end
    checks++; if (obs_en != 0) begin failures++; $display("FAIL equal_enables got=%0d exp=0", obs_en); end
    checks++; if (obs_done_edge != 2) begin failures++; $display("FAIL equal_done_edge got=%0d exp=2", obs_done_edge); end
    checks++; if (obs_done_val !== 2'b01) begin failures++; $display("FAIL equal_done_val got=%b exp=01", obs_done_val); end
  endtask

  task automatic test_sample();
    start0 = 5'd2; limit0 = 5'd4;
    do_job(2'b01, 8, 1'b1);
    checks++; if (obs_data0 !== 5'd2) begin failures++; $display("FAIL sample_data got=%0d exp=2", obs_data0); end
    checks++; if (obs_en != 2) begin failures++; $display("FAIL sample_enables got=%0d exp=2", obs_en); end
    checks++; if (obs_done_edge != 4) begin failures++; $display("FAIL sample_done_edge got=%0d exp=4", obs_done_edge); end
    checks++; if (cnt_data !== 5'd2) begin failures++; $display("FAIL sample_idle_data got=%0d exp=2", cnt_data); end
  endtask

  task automatic test_arb();
    logic [1:0] prev;
    logic [1:0] g_first;
    logic [1:0] g_second;
    logic [1:0] exp_second;
    int         ngr;
    logic       multi;
`ifdef CNT_SCHED_RR_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b01;
`endif
    apply_reset();
    start0 = 5'd1; limit0 = 5'd2; start1 = 5'd4; limit1 = 5'd5;
    prev = 2'b00; g_first = 2'b00; g_second = 2'b00; ngr = 0; multi = 1'b0;
    @(negedge clk);
    req = 2'b11;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gnt == 2'b11) multi = 1'b1;
      if (gnt != 2'b00 && prev == 2'b00) begin
        if (ngr == 0) g_first = gnt;
        else if (ngr == 1) g_second = gnt;
        ngr++;
      end
      prev = gnt;
    end
    req = 2'b00;
    repeat (8) @(negedge clk);
    checks++; if (g_first !== 2'b01) begin failures++; $display("FAIL arb_first got=%b exp=01", g_first); end
    checks++; if (g_second !== exp_second) begin failures++; $display("FAIL arb_second got=%b exp=%b", g_second, exp_second); end
    checks++; if (multi !== 1'b0) begin failures++; $display("FAIL arb_onehot got=%b exp=0", multi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arb_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    logic found;
    logic done_seen;
    start0 = 5'd3; limit0 = 5'd20; start1 = 5'd0; limit1 = 5'd4;
    found = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    req = 2'b01;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (busy && !cnt_load && cnt_model == 5'd5) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL abort_reach_count got=%b exp=1", found); end
    req = 2'b10;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL abort_gnt got=%b exp=00", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL abort_done got=%b exp=00", done); end
    checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL abort_enable got=%b exp=0", cnt_enable); end
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL abort_next_gnt got=%b exp=10", gnt); end
    req = 2'b00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done != 2'b00) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", done_seen); end
  endtask

  task automatic test_async_reset();
    logic found;
    logic done_seen;
    start0 = 5'd3; limit0 = 5'd20;
    found = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    req = 2'b01;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (busy && !cnt_load && cnt_model == 5'd6) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL areset_reach_count got=%b exp=1", found); end
    #2 rst_ = 1'b0;
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL areset_gnt got=%b exp=00", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL areset_enable got=%b exp=0", cnt_enable); end
    checks++; if (cnt_load !== 1'b0) begin failures++; $display("FAIL areset_load got=%b exp=0", cnt_load); end
    checks++; if (cnt_data !== 5'd0) begin failures++; $display("FAIL areset_data got=%0d exp=0", cnt_data); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL areset_done got=%b exp=00", done); end
    req = 2'b00;
    @(negedge clk);
    rst_ = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done != 2'b00) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL areset_no_done got=%b exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_equal();
    test_sample();
    test_arb();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
